cp_dispatch_unit: RTL and testbench
===================================

Name: cp_dispatch_unit

Overview:
Multi-channel coprocessor dispatcher. It sits between the ID/EX pipeline register and CP_NUM coprocessors, and is the parametrised successor of the fixed 3-coprocessor dispatcher. Each channel runs its own issue/wait state machine with a timeout. A pending-rd scoreboard blocks RAW/WAW hazards, and a round-robin arbiter returns results to integer writeback. The block supports flush and reports exceptions.

Parameters:
DATA_WIDTH, 64, operand/result width
INST_WIDTH, 32, instruction width
CP_NUM, 4, coprocessor channel count (2..8)
CP_SEL_W, $clog2(CP_NUM), derived channel-index width
CP_OPCODE, 7'b0001011, opcode identifying coprocessor instructions (custom-0)
TIMEOUT_CYCLES, 256, issue+wait cycle limit per op; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction from ID/EX is valid
in_ready  out  1  dispatcher accepts in_inst this cycle
in_inst  in  INST_WIDTH  instruction
in_rs1_data  in  DATA_WIDTH  rs1 operand
in_rs2_data  in  DATA_WIDTH  rs2 operand
flush  in  1  pipeline flush (branch or trap)
cp_stall_req  out  1  in_valid & is_cp & !in_ready (combinational)
cp_req_valid  out  CP_NUM  per-channel request valid
cp_req_ready  in  CP_NUM  per-channel request ready
cp_req_inst  out  CP_NUM*INST_WIDTH  per-channel instruction, flattened, channel 0 in LSBs
cp_req_data_a  out  CP_NUM*DATA_WIDTH  per-channel rs1 data
cp_req_data_b  out  CP_NUM*DATA_WIDTH  per-channel rs2 data
cp_resp_valid  in  CP_NUM  per-channel response valid
cp_resp_data  in  CP_NUM*DATA_WIDTH  per-channel result
cp_resp_error  in  CP_NUM  response carries an error
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback accepted
wb_rd  out  5  writeback destination register
wb_data  out  DATA_WIDTH  writeback data
exc_valid  out  1  one-cycle exception pulse
exc_cause  out  2  01 illegal channel, 10 timeout, 11 coprocessor error
exc_channel  out  CP_SEL_W  channel that raised the exception
busy  out  CP_NUM  channel not IDLE

Behaviour:
- Reset: all outputs 0 except in_ready, which follows its combinational rule. All channels go to IDLE, the scoreboard is cleared, and the round-robin pointer is 0. Reset asserted mid-operation abandons everything with no writeback and no exception.
- Decode:
  - is_cp = in_inst[6:0]==CP_OPCODE.
  - Channel = in_inst[14:12]; rd=[11:7], rs1=[19:15], rs2=[24:20].
- in_ready:
  - Non-cp instructions: in_ready=1, and the instruction is ignored.
  - Cp instructions: in_ready = !flush & (channel>=CP_NUM | (channel IDLE & no pending rd (nonzero) equal to rs1, rs2 or rd)).
- Accept at cycle T:
  - Channel state becomes ISSUE at T+1, and cp_req_valid[ch]=1 at T+1.
  - Instruction and operands are registered per channel and held stable until the handshake completes.
  - The pending rd is recorded in the scoreboard.
- Illegal channel: the instruction is accepted with no request issued. exc_valid=1 at T+1 with cause 01 and exc_channel = low bits of the channel field.
- Channel FSM:
  - IDLE→ISSUE on accept.
  - ISSUE→WAIT on cp_req_valid&cp_req_ready; cp_req_valid drops in the following cycle.
  - WAIT→DONE on cp_resp_valid with no error and rd!=0; resp_data is latched.
  - WAIT→IDLE on a response with rd==0 (result discarded).
  - WAIT→IDLE on cp_resp_error, with exception cause 11.
  - DONE→IDLE when the arbiter grants the channel and wb_ready=1; the scoreboard entry clears in the same edge.
- cp_resp_valid arriving in ISSUE or IDLE is ignored.
- Timeout:
  - The counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - If the counter equals TIMEOUT_CYCLES-1 with no handshake/response that cycle, the channel goes to IDLE, its scoreboard entry clears, and exception cause 10 is raised.
- Writeback:
  - Among DONE channels, the first at or after the pointer (wrapping) is granted.
  - wb_valid/wb_rd/wb_data are registered. Earliest wb_valid is at R+1 for a response at cycle R.
  - Outputs are held stable while wb_valid & !wb_ready.
  - After a completed transfer, pointer = grant+1 mod CP_NUM.
- Exceptions: one per cycle. Priority: illegal-channel > lowest-numbered channel timeout/error. Lower-priority events in the same cycle are dropped, but their channels still return to IDLE.
- Flush:
  - ISSUE channels → IDLE, request withdrawn at the next edge.
  - WAIT channels set a kill bit; their response sends them to IDLE with no writeback and no exception.
  - DONE channels → IDLE, and any pending wb_valid is dropped.
  - All scoreboard entries clear.
  - Nothing is accepted during the flush cycle.
- Simultaneous accept and DONE→IDLE on the same channel cannot occur, because accept requires the channel to be IDLE.

Decomposition:
- Package cp_dispatch_pkg:
  - cp_state_t enum {IDLE, ISSUE, WAIT, DONE}
  - cp_exc_t enum {NONE=00, ILLEGAL=01, TIMEOUT=10, CPERR=11}
  - CP_OPCODE default
  - Field-offset constants for rd/rs1/rs2/funct3
- Sub-module cp_rr_arbiter: parametrised N-way round-robin with req, grant one-hot, advance input, and pointer register.

Test Plan:
1. Op ch1, funct3=1, rd=5; cp_req_ready=1; response 0xDEADBEEF three cycles after the request → wb_valid rd=5 data=0xDEADBEEF, busy[1] returns to 0 after wb.
2. ch0 pending rd=7; new op ch2 with rs1=7 → in_ready=0 and cp_stall_req=1 until ch0 wb accepted; ch2 request appears the cycle after that.
3. ch0 and ch2 respond in the same cycle, wb_ready=1 → writebacks in order ch0 then ch2. Repeat → ch0 then ch2 (pointer wraps from 3 to 0). With wb_ready=0 for 4 cycles → wb outputs held constant.
4. TIMEOUT_CYCLES=16, cp_req_ready[1] held 0 → exc_valid cause 10, exc_channel 1 on the 16th cycle after cp_req_valid rises; busy[1]=0; rd scoreboard cleared.
5. CP_NUM=4, funct3=5 → accepted, no cp_req_valid, exc cause 01 channel 1 at T+1. cp_resp_error on ch3 → cause 11, no wb.
6. Flush while ch0 in WAIT and ch1 in ISSUE → cp_req_valid[1] drops next cycle; ch0 response produces no wb. Reset asserted with ch2 in DONE → all outputs 0 next cycle.

Source files
------------

// File: rtl/cp_dispatch_pkg.sv
// Shared types and instruction-field constants for the coprocessor dispatcher.
package cp_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } cp_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        ILLEGAL = 2'b01,
        TIMEOUT = 2'b10,
        CPERR   = 2'b11
    } cp_exc_t;

    localparam logic [6:0] CP_OPCODE_DEFAULT = 7'b0001011;

    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;

endpackage

// File: rtl/cp_dispatch_unit_arb.sv
// N-way round-robin arbiter: grants the first requester at or after the
// pointer (wrapping); advance moves the pointer to one past the grant.
module cp_rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] ptr_q;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= SEL_W'((32'(grant_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/cp_dispatch_unit.sv
// Multi-channel coprocessor dispatcher: per-channel issue/wait FSMs with timeout,
// pending-rd hazard scoreboard, round-robin writeback and exception reporting.
module cp_dispatch_unit
    import cp_dispatch_pkg::*;
#(
    parameter int         DATA_WIDTH     = 64,
    parameter int         INST_WIDTH     = 32,
    parameter int         CP_NUM         = 4,
    parameter int         CP_SEL_W       = $clog2(CP_NUM),
    parameter logic [6:0] CP_OPCODE      = CP_OPCODE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INST_WIDTH-1:0]        in_inst,
    input  logic [DATA_WIDTH-1:0]        in_rs1_data,
    input  logic [DATA_WIDTH-1:0]        in_rs2_data,
    input  logic                         flush,
    output logic                         cp_stall_req,
    output logic [CP_NUM-1:0]            cp_req_valid,
    input  logic [CP_NUM-1:0]            cp_req_ready,
    output logic [CP_NUM*INST_WIDTH-1:0] cp_req_inst,
    output logic [CP_NUM*DATA_WIDTH-1:0] cp_req_data_a,
    output logic [CP_NUM*DATA_WIDTH-1:0] cp_req_data_b,
    input  logic [CP_NUM-1:0]            cp_resp_valid,
    input  logic [CP_NUM*DATA_WIDTH-1:0] cp_resp_data,
    input  logic [CP_NUM-1:0]            cp_resp_error,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [4:0]                   wb_rd,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         exc_valid,
    output logic [1:0]                   exc_cause,
    output logic [CP_SEL_W-1:0]          exc_channel,
    output logic [CP_NUM-1:0]            busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    cp_state_t             state  [CP_NUM];
    logic [TO_W-1:0]       cnt    [CP_NUM];
    logic [INST_WIDTH-1:0] inst_q [CP_NUM];
    logic [DATA_WIDTH-1:0] op_a   [CP_NUM];
    logic [DATA_WIDTH-1:0] op_b   [CP_NUM];
    logic [DATA_WIDTH-1:0] res_q  [CP_NUM];
    logic [CP_NUM-1:0]     kill;

    logic       is_cp, ch_illegal, ch_idle, hazard, accept;
    logic [2:0] ch_field;
    logic [4:0] dec_rd, dec_rs1, dec_rs2;

    assign is_cp      = in_inst[6:0] == CP_OPCODE;
    assign ch_field   = in_inst[FUNCT3_LSB +: 3];
    assign dec_rd     = in_inst[RD_LSB +: 5];
    assign dec_rs1    = in_inst[RS1_LSB +: 5];
    assign dec_rs2    = in_inst[RS2_LSB +: 5];
    assign ch_illegal = 32'(ch_field) >= 32'(CP_NUM);

    // Killed (flushed) channels no longer hold a live destination register.
    always_comb begin
        hazard  = 1'b0;
        ch_idle = 1'b0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            if (state[i] != IDLE && !kill[i] && inst_q[i][RD_LSB +: 5] != 5'd0 &&
                (inst_q[i][RD_LSB +: 5] == dec_rs1 || inst_q[i][RD_LSB +: 5] == dec_rs2 ||
                 inst_q[i][RD_LSB +: 5] == dec_rd))
                hazard = 1'b1;
            if (32'(ch_field) == i && state[i] == IDLE)
                ch_idle = 1'b1;
        end
    end

    assign in_ready     = !is_cp || (!flush && (ch_illegal || (ch_idle && !hazard)));
    assign cp_stall_req = in_valid && is_cp && !in_ready;
    assign accept       = in_valid && is_cp && in_ready;

    logic [CP_NUM-1:0]   hs, rsp, to_hit, live, err_ev, to_ev, complete, arb_req, arb_grant;
    logic [CP_SEL_W-1:0] grant_idx, wb_ch;
    logic                load_en;

    always_comb begin
        hs = '0; rsp = '0; to_hit = '0; live = '0;
        err_ev = '0; to_ev = '0; complete = '0; arb_req = '0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            hs[i]       = state[i] == ISSUE && cp_req_ready[i];
            rsp[i]      = state[i] == WAIT && cp_resp_valid[i];
            to_hit[i]   = TIMEOUT_CYCLES != 0 && (state[i] == ISSUE || state[i] == WAIT) &&
                          cnt[i] == TO_LAST && !hs[i] && !rsp[i];
            live[i]     = !kill[i] && !flush;
            err_ev[i]   = rsp[i] && cp_resp_error[i] && live[i];
            to_ev[i]    = to_hit[i] && live[i];
            complete[i] = rsp[i] && !cp_resp_error[i] && live[i] &&
                          inst_q[i][RD_LSB +: 5] != 5'd0;
            // A DONE channel whose result already sits in the wb register stays
            // DONE until that transfer completes, but must not be granted again.
            arb_req[i]  = complete[i] ||
                          (state[i] == DONE && !flush && !(wb_valid && wb_ch == CP_SEL_W'(i)));
        end
    end

    assign load_en = !wb_valid || wb_ready;

    cp_rr_arbiter #(
        .N     (CP_NUM),
        .SEL_W (CP_SEL_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (arb_req),
        .advance   (load_en && |arb_req),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    logic [4:0]            wb_rd_nxt;
    logic [DATA_WIDTH-1:0] wb_data_nxt;

    always_comb begin
        wb_rd_nxt   = '0;
        wb_data_nxt = '0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            if (arb_grant[i]) begin
                wb_rd_nxt   = inst_q[i][RD_LSB +: 5];
                wb_data_nxt = (state[i] == DONE) ? res_q[i]
                                                 : cp_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    logic                exc_v_nxt;
    cp_exc_t             exc_c_nxt, exc_cause_q;
    logic [CP_SEL_W-1:0] exc_ch_nxt;

    always_comb begin
        exc_v_nxt  = 1'b0;
        exc_c_nxt  = NONE;
        exc_ch_nxt = '0;
        if (accept && ch_illegal) begin
            exc_v_nxt  = 1'b1;
            exc_c_nxt  = ILLEGAL;
            exc_ch_nxt = in_inst[FUNCT3_LSB +: CP_SEL_W];
        end else begin
            for (int unsigned i = 0; i < CP_NUM; i++) begin
                if (!exc_v_nxt && (to_ev[i] || err_ev[i])) begin
                    exc_v_nxt  = 1'b1;
                    exc_c_nxt  = to_ev[i] ? TIMEOUT : CPERR;
                    exc_ch_nxt = CP_SEL_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill <= '0;
            for (int unsigned i = 0; i < CP_NUM; i++) begin
                state[i]  <= IDLE;
                cnt[i]    <= '0;
                inst_q[i] <= '0;
                op_a[i]   <= '0;
                op_b[i]   <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CP_NUM; i++) begin
                case (state[i])
                    IDLE: begin
                        if (accept && !ch_illegal && 32'(ch_field) == i) begin
                            state[i]  <= ISSUE;
                            cnt[i]    <= '0;
                            kill[i]   <= 1'b0;
                            inst_q[i] <= in_inst;
                            op_a[i]   <= in_rs1_data;
                            op_b[i]   <= in_rs2_data;
                        end
                    end
                    ISSUE: begin
                        if (flush || (to_hit[i] && !hs[i])) begin
                            state[i] <= IDLE;
                        end else begin
                            if (hs[i]) state[i] <= WAIT;
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (complete[i]) begin
                            state[i] <= DONE;
                            res_q[i] <= cp_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end else if (rsp[i] || to_hit[i]) begin
                            state[i] <= IDLE;
                            kill[i]  <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                            if (flush) kill[i] <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (flush || (wb_valid && wb_ready && wb_ch == CP_SEL_W'(i)))
                            state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_ch    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (load_en) begin
            wb_valid <= |arb_req;
            if (|arb_req) begin
                wb_rd   <= wb_rd_nxt;
                wb_data <= wb_data_nxt;
                wb_ch   <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_valid   <= 1'b0;
            exc_cause_q <= NONE;
            exc_channel <= '0;
        end else begin
            exc_valid   <= exc_v_nxt;
            exc_cause_q <= exc_c_nxt;
            exc_channel <= exc_ch_nxt;
        end
    end

    assign exc_cause = exc_cause_q;

    always_comb begin
        cp_req_valid  = '0;
        busy          = '0;
        cp_req_inst   = '0;
        cp_req_data_a = '0;
        cp_req_data_b = '0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            cp_req_valid[i] = state[i] == ISSUE;
            busy[i]         = state[i] != IDLE;
            cp_req_inst[i*INST_WIDTH +: INST_WIDTH]   = inst_q[i];
            cp_req_data_a[i*DATA_WIDTH +: DATA_WIDTH] = op_a[i];
            cp_req_data_b[i*DATA_WIDTH +: DATA_WIDTH] = op_b[i];
        end
    end

endmodule

// File: tb/tb_cp_dispatch_unit.sv
// Directed self-checking bench for cp_dispatch_unit (4 channels, 16-cycle timeout).
module tb_cp_dispatch_unit;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush, cp_stall_req;
    logic [IW-1:0] in_inst;
    logic [DW-1:0] in_rs1_data, in_rs2_data;
    logic [N-1:0]  cp_req_valid, cp_req_ready, cp_resp_valid, cp_resp_error, busy;
    logic [N*IW-1:0] cp_req_inst;
    logic [N*DW-1:0] cp_req_data_a, cp_req_data_b, cp_resp_data;
    logic          wb_valid, wb_ready, exc_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic [1:0]    exc_cause;
    logic [SW-1:0] exc_channel;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cp_dispatch_unit #(
        .DATA_WIDTH     (DW),
        .INST_WIDTH     (IW),
        .CP_NUM         (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready), .in_inst (in_inst),
        .in_rs1_data (in_rs1_data), .in_rs2_data (in_rs2_data),
        .flush (flush), .cp_stall_req (cp_stall_req),
        .cp_req_valid (cp_req_valid), .cp_req_ready (cp_req_ready),
        .cp_req_inst (cp_req_inst), .cp_req_data_a (cp_req_data_a),
        .cp_req_data_b (cp_req_data_b), .cp_resp_valid (cp_resp_valid),
        .cp_resp_data (cp_resp_data), .cp_resp_error (cp_resp_error),
        .wb_valid (wb_valid), .wb_ready (wb_ready), .wb_rd (wb_rd), .wb_data (wb_data),
        .exc_valid (exc_valid), .exc_cause (exc_cause), .exc_channel (exc_channel),
        .busy (busy)
    );

    function automatic logic [31:0] mk(input logic [2:0] ch, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, ch, rd, 7'b0001011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_rs1_data = '0; in_rs2_data = '0;
        flush = 1'b0; cp_req_ready = '0; cp_resp_valid = '0; cp_resp_data = '0;
        cp_resp_error = '0; wb_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1; in_inst = inst; in_rs1_data = a; in_rs2_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else passed++;
        checks++; if (cp_req_valid !== 4'b0) $display("FAIL reset_req_valid got=%b exp=0000", cp_req_valid); else passed++;
        checks++; if (busy !== 4'b0) $display("FAIL reset_busy got=%b exp=0000", busy); else passed++;
        checks++; if ({wb_valid, exc_valid, cp_stall_req} !== 3'b0)
            $display("FAIL reset_flags got=%b exp=000", {wb_valid, exc_valid, cp_stall_req}); else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] inst;
        do_reset();
        inst = mk(3'd1, 5'd5, 5'd3, 5'd4);
        cp_req_ready = 4'b0010; wb_ready = 1'b1;
        in_valid = 1'b1; in_inst = inst; in_rs1_data = 64'h1111; in_rs2_data = 64'h2222;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got=%0b exp=1", in_ready); else passed++;
        tick(); in_valid = 1'b0;
        checks++; if (cp_req_valid !== 4'b0010) $display("FAIL basic_req_valid got=%b exp=0010", cp_req_valid); else passed++;
        checks++; if (cp_req_inst[IW +: IW] !== inst) $display("FAIL basic_req_inst got=%h exp=%h", cp_req_inst[IW +: IW], inst); else passed++;
        checks++; if (cp_req_data_a[DW +: DW] !== 64'h1111) $display("FAIL basic_data_a got=%h exp=1111", cp_req_data_a[DW +: DW]); else passed++;
        checks++; if (cp_req_data_b[DW +: DW] !== 64'h2222) $display("FAIL basic_data_b got=%h exp=2222", cp_req_data_b[DW +: DW]); else passed++;
        tick(); cp_req_ready = '0;
        checks++; if (cp_req_valid !== 4'b0) $display("FAIL basic_req_drop got=%b exp=0000", cp_req_valid); else passed++;
        checks++; if (busy !== 4'b0010) $display("FAIL basic_busy_wait got=%b exp=0010", busy); else passed++;
        tick(); tick();
        checks++; if (wb_valid !== 1'b0) $display("FAIL basic_no_early_wb got=%0b exp=0", wb_valid); else passed++;
        cp_resp_valid = 4'b0010; cp_resp_data[DW +: DW] = 64'hDEADBEEF;
        tick(); cp_resp_valid = '0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'hDEADBEEF)
            $display("FAIL basic_wb got=%0b/%0d/%h exp=1/5/deadbeef", wb_valid, wb_rd, wb_data); else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0 || busy !== 4'b0)
            $display("FAIL basic_after_wb got=%0b/%b exp=0/0000", wb_valid, busy); else passed++;
    endtask

    task automatic test_hazard();
        do_reset();
        cp_req_ready = 4'b0001;
        issue(mk(3'd0, 5'd7, 5'd1, 5'd2), 64'h1, 64'h2);
        tick();
        cp_resp_valid = 4'b0001; cp_resp_data[0 +: DW] = 64'h77;
        tick(); cp_resp_valid = '0;
        in_valid = 1'b1; in_inst = mk(3'd2, 5'd9, 5'd7, 5'd3); cp_req_ready = 4'b0100;
        #1;
        checks++; if (in_ready !== 1'b0 || cp_stall_req !== 1'b1)
            $display("FAIL hazard_stall got=%0b/%0b exp=0/1", in_ready, cp_stall_req); else passed++;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h77)
            $display("FAIL hazard_wb got=%0b/%0d/%h exp=1/7/77", wb_valid, wb_rd, wb_data); else passed++;
        tick();
        checks++; if (in_ready !== 1'b0 || cp_req_valid !== 4'b0)
            $display("FAIL hazard_held got=%0b/%b exp=0/0000", in_ready, cp_req_valid); else passed++;
        wb_ready = 1'b1;
        tick(); wb_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || cp_stall_req !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL hazard_release got=%0b/%0b/%0b exp=1/0/0", in_ready, cp_stall_req, wb_valid); else passed++;
        tick(); in_valid = 1'b0;
        checks++; if (cp_req_valid !== 4'b0100) $display("FAIL hazard_ch2_req got=%b exp=0100", cp_req_valid); else passed++;
    endtask

    task automatic test_round_robin();
        logic [4:0]    rd0 [2];
        logic [4:0]    rd2 [2];
        logic [DW-1:0] d0  [2];
        logic [DW-1:0] d2  [2];
        rd0 = '{5'd10, 5'd11}; rd2 = '{5'd12, 5'd13};
        d0 = '{64'hA0, 64'hB0}; d2 = '{64'hC2, 64'hD2};
        do_reset();
        cp_req_ready = 4'b0101; wb_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            issue(mk(3'd0, rd0[r], 5'd1, 5'd2), 64'h0, 64'h0);
            issue(mk(3'd2, rd2[r], 5'd1, 5'd2), 64'h0, 64'h0);
            tick();
            cp_resp_valid = 4'b0101; cp_resp_data[0 +: DW] = d0[r]; cp_resp_data[2*DW +: DW] = d2[r];
            tick(); cp_resp_valid = '0;
            checks++; if (wb_valid !== 1'b1 || wb_rd !== rd0[r] || wb_data !== d0[r])
                $display("FAIL rr_first_%0d got=%0b/%0d/%h exp=1/%0d/%h", r, wb_valid, wb_rd, wb_data, rd0[r], d0[r]); else passed++;
            tick();
            checks++; if (wb_valid !== 1'b1 || wb_rd !== rd2[r] || wb_data !== d2[r])
                $display("FAIL rr_second_%0d got=%0b/%0d/%h exp=1/%0d/%h", r, wb_valid, wb_rd, wb_data, rd2[r], d2[r]); else passed++;
            tick();
            checks++; if (wb_valid !== 1'b0 || busy !== 4'b0)
                $display("FAIL rr_drain_%0d got=%0b/%b exp=0/0000", r, wb_valid, busy); else passed++;
        end
        wb_ready = 1'b0;
        issue(mk(3'd0, 5'd20, 5'd1, 5'd2), 64'h0, 64'h0);
        tick();
        cp_resp_valid = 4'b0001; cp_resp_data[0 +: DW] = 64'hE0E0;
        tick(); cp_resp_valid = '0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd20 || wb_data !== 64'hE0E0)
                $display("FAIL rr_hold_%0d got=%0b/%0d/%h exp=1/20/e0e0", k, wb_valid, wb_rd, wb_data); else passed++;
            tick();
        end
        wb_ready = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) $display("FAIL rr_hold_release got=%0b exp=0", wb_valid); else passed++;
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        issue(mk(3'd1, 5'd6, 5'd1, 5'd2), 64'h0, 64'h0);
        checks++; if (cp_req_valid !== 4'b0010) $display("FAIL to_req got=%b exp=0010", cp_req_valid); else passed++;
        early = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (exc_valid !== 1'b0 || busy[1] !== 1'b1) early++;
        end
        checks++; if (early != 0) $display("FAIL to_early got=%0d exp=0", early); else passed++;
        tick();
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 2'b10 || exc_channel !== 2'd1)
            $display("FAIL to_exc got=%0b/%b/%0d exp=1/10/1", exc_valid, exc_cause, exc_channel); else passed++;
        checks++; if (busy !== 4'b0 || cp_req_valid !== 4'b0)
            $display("FAIL to_idle got=%b/%b exp=0000/0000", busy, cp_req_valid); else passed++;
        in_inst = mk(3'd2, 5'd9, 5'd6, 5'd1);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL to_sb_clear got=%0b exp=1", in_ready); else passed++;
        tick();
        checks++; if (exc_valid !== 1'b0) $display("FAIL to_pulse got=%0b exp=0", exc_valid); else passed++;
    endtask

    task automatic test_exceptions();
        do_reset();
        in_valid = 1'b1; in_inst = mk(3'd5, 5'd8, 5'd1, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL ill_accept got=%0b exp=1", in_ready); else passed++;
        tick(); in_valid = 1'b0;
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 2'b01 || exc_channel !== 2'd1)
            $display("FAIL ill_exc got=%0b/%b/%0d exp=1/01/1", exc_valid, exc_cause, exc_channel); else passed++;
        checks++; if (cp_req_valid !== 4'b0 || busy !== 4'b0)
            $display("FAIL ill_noreq got=%b/%b exp=0000/0000", cp_req_valid, busy); else passed++;
        cp_req_ready = 4'b1000; wb_ready = 1'b1;
        issue(mk(3'd3, 5'd9, 5'd1, 5'd2), 64'h0, 64'h0);
        tick();
        cp_resp_valid = 4'b1000; cp_resp_error = 4'b1000; cp_resp_data[3*DW +: DW] = 64'h99;
        tick(); cp_resp_valid = '0; cp_resp_error = '0;
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 2'b11 || exc_channel !== 2'd3)
            $display("FAIL err_exc got=%0b/%b/%0d exp=1/11/3", exc_valid, exc_cause, exc_channel); else passed++;
        checks++; if (wb_valid !== 1'b0 || busy !== 4'b0)
            $display("FAIL err_nowb got=%0b/%b exp=0/0000", wb_valid, busy); else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0 || exc_valid !== 1'b0)
            $display("FAIL err_after got=%0b/%0b exp=0/0", wb_valid, exc_valid); else passed++;
    endtask

    task automatic test_flush_reset();
        do_reset();
        cp_req_ready = 4'b0001;
        issue(mk(3'd0, 5'd4, 5'd1, 5'd2), 64'h0, 64'h0);
        issue(mk(3'd1, 5'd5, 5'd1, 5'd2), 64'h0, 64'h0);
        checks++; if (cp_req_valid !== 4'b0010 || busy !== 4'b0011)
            $display("FAIL fl_setup got=%b/%b exp=0010/0011", cp_req_valid, busy); else passed++;
        flush = 1'b1; in_valid = 1'b1; in_inst = mk(3'd2, 5'd9, 5'd1, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL fl_no_accept got=%0b exp=0", in_ready); else passed++;
        tick(); flush = 1'b0; in_valid = 1'b0; in_inst = mk(3'd2, 5'd9, 5'd4, 5'd1);
        #1;
        checks++; if (cp_req_valid !== 4'b0 || busy !== 4'b0001 || in_ready !== 1'b1)
            $display("FAIL fl_state got=%b/%b/%0b exp=0000/0001/1", cp_req_valid, busy, in_ready); else passed++;
        cp_resp_valid = 4'b0001; cp_resp_data[0 +: DW] = 64'h44; wb_ready = 1'b1;
        tick(); cp_resp_valid = '0;
        checks++; if (wb_valid !== 1'b0 || exc_valid !== 1'b0 || busy !== 4'b0)
            $display("FAIL fl_killed got=%0b/%0b/%b exp=0/0/0000", wb_valid, exc_valid, busy); else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0) $display("FAIL fl_nowb got=%0b exp=0", wb_valid); else passed++;
        cp_req_ready = 4'b0100; wb_ready = 1'b0;
        issue(mk(3'd2, 5'd3, 5'd1, 5'd2), 64'h5, 64'h6);
        tick();
        cp_resp_valid = 4'b0100; cp_resp_data[2*DW +: DW] = 64'h33;
        tick(); cp_resp_valid = '0;
        checks++; if (wb_valid !== 1'b1 || busy !== 4'b0100)
            $display("FAIL rst_setup got=%0b/%b exp=1/0100", wb_valid, busy); else passed++;
        reset = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'h0 || busy !== 4'b0 ||
                      exc_valid !== 1'b0 || cp_req_valid !== 4'b0 || cp_req_inst !== '0)
            $display("FAIL rst_mid got=%0b/%0d/%h/%b/%0b/%b exp=0/0/0/0000/0/0000",
                     wb_valid, wb_rd, wb_data, busy, exc_valid, cp_req_valid); else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard();
        test_round_robin();
        test_timeout();
        test_exceptions();
        test_flush_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
